// File: rtl/aes_key_expander_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander_if
// Brief    : Controller <-> key expander interface: key load, round index,
//            round key and ready flag.
// Revision : 1.0 - initial release
// ============================================================================
interface aes_key_expander_if;
  logic         key_load;
  logic [127:0] key_in;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         key_ready;

  // Controller side
  modport master (
    output key_load,
    output key_in,
    output round,
    input  round_key,
    input  key_ready
  );

  // Key expander side
  modport slave (
    input  key_load,
    input  key_in,
    input  round,
    output round_key,
    output key_ready
  );
endinterface
`default_nettype wire

// File: rtl/aes_key_expander.sv
`default_nettype none
// ============================================================================
// Module   : aes_key_expander
// Brief    : AES-128 key schedule. Captures a cipher key, expands the 11
//            round keys one per clock into local storage and serves any of
//            them combinationally by round index.
// Revision : 1.0 - initial release
// ============================================================================

// AES S-box computed as GF(2^8) inverse (a^254) followed by the affine map.
module aes_key_expander_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 = a^2 * a^4 * ... * a^128; zero maps to zero naturally.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  // Inverse, then affine transform: x ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv
           ^ {w_inv[6:0], w_inv[7]}
           ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]}
           ^ {w_inv[3:0], w_inv[7:4]}
           ^ 8'h63;
  end
endmodule

module aes_key_expander #(
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                n_rst,
  aes_key_expander_if.slave   bus
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_expander: only NR = 10 (AES-128) is supported");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_IDX = 4'(NR);

  state_t       r_state;
  state_t       w_state_next;
  logic [127:0] r_key_mem [0:NR];
  logic [3:0]   r_idx;
  logic [7:0]   r_rcon;

  logic [3:0]   w_prev_idx;
  logic [127:0] w_prev;
  logic [31:0]  w_rot;
  logic [31:0]  w_sub;
  logic [31:0]  w_t;
  logic [127:0] w_new;

  // Source word index for the key being generated (guarded outside EXPAND).
  always_comb begin
    w_prev_idx = r_idx - 4'd1;
    if (r_idx == 4'd0 || r_idx > C_LAST_IDX) w_prev_idx = 4'd0;
  end

  assign w_prev = r_key_mem[w_prev_idx];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};

  for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
    aes_key_expander_sbox u_sbox (
      .i_byte (w_rot[8*gi +: 8]),
      .o_byte (w_sub[8*gi +: 8])
    );
  end

  // Next round key: chained XOR of the previous four words.
  always_comb begin
    w_t            = w_sub ^ {r_rcon, 24'h0};
    w_new[127:96]  = w_prev[127:96] ^ w_t;
    w_new[95:64]   = w_prev[95:64]  ^ w_new[127:96];
    w_new[63:32]   = w_prev[63:32]  ^ w_new[95:64];
    w_new[31:0]    = w_prev[31:0]   ^ w_new[63:32];
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: a load always (re)starts expansion; last write ends it.
  always_comb begin
    w_state_next = r_state;
    if (bus.key_load) begin
      w_state_next = EXPAND;
    end else begin
      case (r_state)
        EXPAND:  if (r_idx == C_LAST_IDX) w_state_next = READY;
        default: w_state_next = r_state;
      endcase
    end
  end

  // Index and round constant: reset on load, advance (xtime) while expanding.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_idx  <= 4'd0;
      r_rcon <= 8'h01;
    end else if (bus.key_load) begin
      r_idx  <= 4'd1;
      r_rcon <= 8'h01;
    end else if (r_state == EXPAND) begin
      r_idx  <= r_idx + 4'd1;
      r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
    end
  end

  // Round key storage: cipher key into slot 0, expanded keys into slot idx.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i <= NR; i++) r_key_mem[i] <= '0;
    end else if (bus.key_load) begin
      r_key_mem[0] <= bus.key_in;
    end else if (r_state == EXPAND) begin
      r_key_mem[r_idx] <= w_new;
    end
  end

  // Random-access read; indices beyond the last round return zero.
  always_comb begin
    bus.round_key = '0;
    if (bus.round <= C_LAST_IDX) bus.round_key = r_key_mem[bus.round];
  end

  assign bus.key_ready = (r_state == READY);

endmodule
`default_nettype wire
